// File: rtl/sample_fifo.sv
// First-word-fall-through sample buffer with level, almost-full and sticky error flags.
// The head word is presented combinationally on sample; status flags come from the registered level.
module sample_fifo #(
  parameter int unsigned DEPTH    = 512,
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned AF_LEVEL = DEPTH - 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       wr_en,
  output logic                       full,
  output logic                       almost_full,
  output logic [WIDTH-1:0]           sample,
  output logic                       empty,
  input  logic                       read,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       clr_err,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             rd_acc;
  logic             wr_acc;
  logic [LW-1:0]    level_nxt;

  // A read frees the slot this cycle, so a write into a full FIFO is legal alongside it.
  always_comb begin
    rd_acc = read & ~empty;
    wr_acc = wr_en & (~full | rd_acc);
  end

  always_comb begin
    level_nxt = level;
    unique case ({wr_acc, rd_acc})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // Pointers, level and the flags derived from it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      empty       <= 1'b1;
      full        <= 1'b0;
      almost_full <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      level       <= level_nxt;
      empty       <= (level_nxt == '0);
      full        <= (level_nxt == LW'(DEPTH));
      almost_full <= (level_nxt >= LW'(AF_LEVEL));
    end
  end

  // Sticky error flags; a new error in the clearing cycle wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      overflow  <= (wr_en & ~wr_acc) | (overflow & ~clr_err);
      underflow <= (read & empty) | (underflow & ~clr_err);
    end
  end

  // Storage is not reset; only the pointers define its contents.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr] <= wr_data;
  end

  assign sample = mem[rd_ptr];

endmodule

// File: tb/tb_sample_fifo.sv
// Self-checking bench for sample_fifo (DEPTH=16, AF_LEVEL=12) against a queue-based model.
module tb_sample_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AF    = 12;

  logic       clk;
  logic       rst;
  logic [7:0] wr_data;
  logic       wr_en;
  logic       full;
  logic       almost_full;
  logic [7:0] sample;
  logic       empty;
  logic       read;
  logic [4:0] level;
  logic       clr_err;
  logic       overflow;
  logic       underflow;

  sample_fifo #(.DEPTH(DEPTH), .WIDTH(8), .AF_LEVEL(AF)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_data     (wr_data),
    .wr_en       (wr_en),
    .full        (full),
    .almost_full (almost_full),
    .sample      (sample),
    .empty       (empty),
    .read        (read),
    .level       (level),
    .clr_err     (clr_err),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_unf;

  typedef struct {
    logic       w;
    logic [7:0] d;
    logic       r;
    logic       c;
    int         lvl;
    logic       emp;
    logic [7:0] smp;
    logic       unf;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic check_model();
    int n;
    n = q.size();
    chk("level", 32'(level), n);
    chk("empty", 32'(empty), int'(n == 0));
    chk("full", 32'(full), int'(n == int'(DEPTH)));
    chk("almost_full", 32'(almost_full), int'(n >= int'(AF)));
    chk("overflow", 32'(overflow), int'(m_ovf));
    chk("underflow", 32'(underflow), int'(m_unf));
    if (n > 0) chk("sample", 32'(sample), 32'(q[0]));
  endtask

  // Apply one cycle of inputs, advance the model, and compare after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r, input logic c);
    bit m_full, m_empty, ra, wa;
    wr_en = w; wr_data = d; read = r; clr_err = c;
    m_empty = (q.size() == 0);
    m_full  = (q.size() == int'(DEPTH));
    ra = r && !m_empty;
    wa = w && (!m_full || ra);
    m_ovf = (w && !wa) || (m_ovf && !c);
    m_unf = (r && m_empty) || (m_unf && !c);
    if (ra) void'(q.pop_front());
    if (wa) q.push_back(d);
    @(posedge clk);
    #1;
    check_model();
  endtask

  initial begin
    rst = 1'b0; wr_en = 1'b0; wr_data = '0; read = 1'b0; clr_err = 1'b0;
    m_ovf = 0; m_unf = 0;

    tbl[0]  = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 8'h11, 1'b0};
    tbl[1]  = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 8'h11, 1'b0};
    tbl[2]  = '{1'b1, 8'h33, 1'b0, 1'b0, 3, 1'b0, 8'h11, 1'b0};
    tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 8'h22, 1'b0};
    tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 8'h33, 1'b0};
    tbl[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h00, 1'b0};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 8'h00, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 8'h00, 1'b0};
    tbl[8]  = '{1'b1, 8'h44, 1'b1, 1'b0, 1, 1'b0, 8'h44, 1'b1};
    tbl[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 8'h00, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b1, 1'b1, 0, 1'b1, 8'h00, 1'b1};
    tbl[11] = '{1'b0, 8'h00, 1'b0, 1'b1, 0, 1'b1, 8'h00, 1'b0};

    #12;
    chk("reset_empty", 32'(empty), 1);
    chk("reset_level", 32'(level), 0);
    chk("reset_full", 32'(full), 0);
    chk("reset_af", 32'(almost_full), 0);
    chk("reset_ovf", 32'(overflow), 0);
    chk("reset_unf", 32'(underflow), 0);
    #5 rst = 1'b1;

    // Directed table: basic push/pop, underflow, empty collision, clear priority.
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].w, tbl[i].d, tbl[i].r, tbl[i].c);
      chk($sformatf("tbl%0d_level", i), 32'(level), tbl[i].lvl);
      chk($sformatf("tbl%0d_empty", i), 32'(empty), 32'(tbl[i].emp));
      chk($sformatf("tbl%0d_unf", i), 32'(underflow), 32'(tbl[i].unf));
      if (!tbl[i].emp) chk($sformatf("tbl%0d_sample", i), 32'(sample), 32'(tbl[i].smp));
    end

    // Fill past capacity: almost_full from 12, full at 16, 17th word dropped.
    for (int i = 0; i < 17; i++) begin
      step(1'b1, 8'(i), 1'b0, 1'b0);
      chk("fill_af", 32'(almost_full), int'(((i < 16) ? i + 1 : 16) >= 12));
      chk("fill_full", 32'(full), int'(i >= 15));
    end
    chk("fill_ovf", 32'(overflow), 1);
    for (int i = 0; i < 16; i++) begin
      chk("drain_order", 32'(sample), i);
      step(1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("drain_empty", 32'(empty), 1);
    step(1'b0, 8'h00, 1'b0, 1'b1);

    // Full collision: simultaneous write and read keeps level at DEPTH.
    for (int i = 0; i < 16; i++) step(1'b1, 8'(100 + i), 1'b0, 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b0);
    chk("fullcol_level", 32'(level), 16);
    chk("fullcol_ovf", 32'(overflow), 0);
    chk("fullcol_sample", 32'(sample), 101);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Pointer wrap: steady-state streaming at level 8.
    for (int i = 0; i < 8; i++) step(1'b1, 8'(50 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(150 + i), 1'b1, 1'b0);
      chk("wrap_level", 32'(level), 8);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

    // Asynchronous reset mid-stream.
    for (int i = 0; i < 5; i++) step(1'b1, 8'(30 + i), 1'b0, 1'b0);
    chk("prerst_level", 32'(level), 5);
    wr_en = 1'b0; read = 1'b0; clr_err = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_empty", 32'(empty), 1);
    chk("arst_level", 32'(level), 0);
    q.delete(); m_ovf = 0; m_unf = 0;
    @(posedge clk);
    #3 rst = 1'b1;
    step(1'b1, 8'hA5, 1'b0, 1'b0);
    chk("postrst_sample", 32'(sample), 32'hA5);
    chk("postrst_level", 32'(level), 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("postrst_empty", 32'(empty), 1);

    // Randomized traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      step(1'($urandom_range(0, 99) < 55), 8'($urandom), 1'($urandom_range(0, 99) < 45),
           1'($urandom_range(0, 99) < 5));
    end
    step(1'b0, 8'h00, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
